pwm_peripheral: RTL and testbench

//   Consumes the five control registers produced by the SPI register block and drives 16 output pins.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_timebase.sv | 40 ++++
 rtl/pwm_peripheral.sv | 77 +++++++
 tb/tb_pwm_peripheral.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Purpose : shared types, widths and the PWM compare helper for the PWM peripheral.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: PWM_CNT_W, PWM_DUTY_FULL, NUM_OUT, pwm_cnt_t, pin_vec_t, pin_cfg_t, pwm_level().
package pwm_pkg;

   localparam int PWM_CNT_W = 8;
   localparam int NUM_OUT   = 16;

   typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
   typedef logic [NUM_OUT-1:0]   pin_vec_t;

   localparam pwm_cnt_t PWM_DUTY_FULL = 8'hFF;

   // Per-pin configuration gathered from the register block.
   typedef struct packed {
      pin_vec_t en_out;   // 1 = pin active
      pin_vec_t en_pwm;   // 1 = PWM waveform, 0 = static high
   } pin_cfg_t;

   // Full-scale duty is 100 %: a plain compare would leave count 255 low.
   function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
      return (duty == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Purpose : prescaled 8-bit PWM timebase (prescaler + free-running count).
// Latency : tick is combinational from the prescaler; wrap is registered, high in the clk after the 255->0 tick.
// Backpres: none; free-running.
// Ports   : clk, rst_n (async active-low) | tick (1 clk per PRESCALE), pwm_cnt (8b), wrap (period-start pulse).
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic     clk,
   input  logic     rst_n,
   output logic     tick,
   output pwm_cnt_t pwm_cnt,
   output logic     wrap
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] prescaler;

   // With PRESCALE == 1 the prescaler sits at 0 and tick is held high.
   assign tick = (prescaler == PS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
         wrap      <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PS_W'(1);
         if (tick) begin
            pwm_cnt <= pwm_cnt + pwm_cnt_t'(1);
         end
         // Lines up with pwm_cnt reading 0 at the start of each period.
         wrap <= tick && (pwm_cnt == PWM_DUTY_FULL);
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// Purpose : 16-pin output stage: per pin off / static high / shared 8-bit PWM.
// Latency : enable/select -> out 1 clk; duty -> out 1 clk, or next period start with PWM_DUTY_SHADOW_EN.
// Backpres: none; register inputs are sampled every clk.
// Ports   : clk, rst_n (async active-low); en_reg_out_{7_0,15_8}, en_reg_pwm_{7_0,15_8}, pwm_duty_cycle (8b each)
//           -> out (16b pin drive), pwm_period_start (1-clk pulse when the PWM count wraps 255->0).
// Option  : define PWM_DUTY_SHADOW_EN to load the duty only at period boundaries (glitch-free duty updates).
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output pin_vec_t   out,
   output logic       pwm_period_start
);

   logic     tick;
   pwm_cnt_t pwm_cnt;
   pwm_cnt_t duty_act;
   logic     pwm_sig;
   pin_cfg_t cfg;
   pin_vec_t pin_next;

   pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wrap    (pwm_period_start)
   );

   assign cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_DUTY_SHADOW_EN
   // Loaded on the tick that takes the count 255->0, so every period runs
   // with a single duty value; a write landing in that same clk is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_act <= '0;
      end else if (tick && (pwm_cnt == PWM_DUTY_FULL)) begin
         duty_act <= pwm_duty_cycle;
      end
   end
`else
   // Duty follows the register directly; tick is only needed by the shadow.
   logic unused_tick;
   assign unused_tick = tick;
   assign duty_act    = pwm_duty_cycle;
`endif

   assign pwm_sig = pwm_level(pwm_cnt, duty_act);

   always_comb begin
      pin_next = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         pin_next[i] = cfg.en_out[i] & (cfg.en_pwm[i] ? pwm_sig : 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= pin_next;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Purpose : directed self-checking bench for pwm_peripheral (PRESCALE=13 instance plus a PRESCALE=1 instance).
// Latency : n/a.
// Backpres: n/a.
module tb_pwm_peripheral;

   localparam int P   = 13;
   localparam int PER = 256 * P;

   logic        clk;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        pwm_period_start;
   logic [15:0] out_p1;
   logic        pwm_period_start_p1;

   int n_cmp  = 0;
   int n_fail = 0;

   pwm_peripheral #(.PRESCALE(P)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .en_reg_out_7_0   (en_reg_out_7_0),
      .en_reg_out_15_8  (en_reg_out_15_8),
      .en_reg_pwm_7_0   (en_reg_pwm_7_0),
      .en_reg_pwm_15_8  (en_reg_pwm_15_8),
      .pwm_duty_cycle   (pwm_duty_cycle),
      .out              (out),
      .pwm_period_start (pwm_period_start)
   );

   pwm_peripheral #(.PRESCALE(1)) u_dut_p1 (
      .clk              (clk),
      .rst_n            (rst_n),
      .en_reg_out_7_0   (en_reg_out_7_0),
      .en_reg_out_15_8  (en_reg_out_15_8),
      .en_reg_pwm_7_0   (en_reg_pwm_7_0),
      .en_reg_pwm_15_8  (en_reg_pwm_15_8),
      .pwm_duty_cycle   (pwm_duty_cycle),
      .out              (out_p1),
      .pwm_period_start (pwm_period_start_p1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns the number of negedges until the selected instance shows a
   // period-start pulse, or -1 if none appears within one period plus slack.
   task automatic wait_start(input bit p1, output int n);
      n = -1;
      for (int k = 1; k <= PER + 16; k++) begin
         @(negedge clk);
         if ((p1 ? pwm_period_start_p1 : pwm_period_start) === 1'b1) begin
            n = k;
            return;
         end
      end
   endtask

   // Called on a period-start sample; walks one full period of samples.
   task automatic measure(output int hi, output int any, output int starts);
      hi = 0; any = 0; starts = 0;
      for (int j = 0; j < PER; j++) begin
         if (out[0] === 1'b1) hi++;
         if (out !== 16'h0) any++;
         if (pwm_period_start === 1'b1) starts++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n, hi, any, starts;

      // ---- 1: reset state, all pins disabled ----
      rst_n = 1'b0;
      en_reg_out_7_0 = 8'h00; en_reg_out_15_8 = 8'h00;
      en_reg_pwm_7_0 = 8'h00; en_reg_pwm_15_8 = 8'h00;
      pwm_duty_cycle = 8'h80;
      repeat (3) @(negedge clk);
      check("reset_out", out, 16'h0);
      check("reset_pws", pwm_period_start, 1'b0);
      check("reset_out_p1", out_p1, 16'h0);
      check("reset_pws_p1", pwm_period_start_p1, 1'b0);
      rst_n = 1'b1;
      wait_start(1'b0, n);
      check("t1_first_start_latency", n, PER);
      for (int r = 0; r < 2; r++) begin
         measure(hi, any, starts);
         check("t1_out_idle", any, 0);
         check("t1_starts_per_period", starts, 1);
         check("t1_period_spacing", pwm_period_start, 1'b1);
      end

      // ---- 2: enable / select mux, 1-clk latency ----
      en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hFF;
      #1;
      check("t2_before_edge", out, 16'h0);
      @(negedge clk);
      check("t2_all_high", out, 16'hFFFF);
      en_reg_out_7_0 = 8'hF7;
      @(negedge clk);
      check("t2_clear_pin3", out, 16'hFFF7);
      en_reg_out_7_0 = 8'h00; en_reg_out_15_8 = 8'h80;
      @(negedge clk);
      check("t2_pin15_only", out, 16'h8000);
      en_reg_out_7_0 = 8'h00; en_reg_out_15_8 = 8'h00;
      en_reg_pwm_7_0 = 8'hFF; en_reg_pwm_15_8 = 8'hFF;
      pwm_duty_cycle = 8'hFF;
      @(negedge clk);
      check("t2_pwm_sel_without_enable", out, 16'h0);
`ifndef PWM_DUTY_SHADOW_EN
      en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hFF;
      pwm_duty_cycle = 8'h00;
      @(negedge clk);
      check("t2_pwm_duty0", out, 16'h0);
      pwm_duty_cycle = 8'hFF;
      @(negedge clk);
      check("t2_pwm_duty_full", out, 16'hFFFF);
      en_reg_pwm_7_0 = 8'h00; en_reg_pwm_15_8 = 8'hFF;
      pwm_duty_cycle = 8'h00;
      @(negedge clk);
      check("t2_mixed_static_pwm", out, 16'h00FF);
`endif

      // ---- 3: single PWM pin, duty 0 / 0x40 / 0xFF ----
      en_reg_out_7_0 = 8'h01; en_reg_out_15_8 = 8'h00;
      en_reg_pwm_7_0 = 8'h01; en_reg_pwm_15_8 = 8'h00;
      pwm_duty_cycle = 8'h00;
      wait_start(1'b0, n);
      check("t3_start_found_d00", (n > 0), 1'b1);
      measure(hi, any, starts);
      check("t3_high_d00", hi, 0);
      pwm_duty_cycle = 8'h40;
      wait_start(1'b0, n);
      check("t3_period_d40", n, PER);
      measure(hi, any, starts);
      check("t3_high_d40", hi, 64 * P);
      pwm_duty_cycle = 8'hFF;
      wait_start(1'b0, n);
      wait_start(1'b0, n);
      measure(hi, any, starts);
      check("t3_high_dff", hi, PER);

      // ---- 4: duty 0x40 -> 0xC0 at pwm_cnt 0x20 ----
      pwm_duty_cycle = 8'h40;
      wait_start(1'b0, n);
      wait_start(1'b0, n);
      hi = 0;
      for (int j = 0; j < PER; j++) begin
         if (j == 32 * P) pwm_duty_cycle = 8'hC0;
         if (out[0] === 1'b1) hi++;
         @(negedge clk);
      end
`ifdef PWM_DUTY_SHADOW_EN
      check("t4_current_period", hi, 64 * P);
`else
      check("t4_current_period", hi, 192 * P);
`endif
      check("t4_period_boundary", pwm_period_start, 1'b1);
      measure(hi, any, starts);
      check("t4_next_period", hi, 192 * P);

      // ---- 5: PRESCALE=1 instance, 4 period spacings ----
      wait_start(1'b1, n);
      check("t5_p1_start_found", (n > 0), 1'b1);
      for (int r = 0; r < 4; r++) begin
         wait_start(1'b1, n);
         check("t5_p1_spacing", n, 256);
      end

      // ---- 6: reset mid-pulse ----
      pwm_duty_cycle = 8'h40;
      wait_start(1'b0, n);
      wait_start(1'b0, n);
      repeat (16 * P + 2) @(negedge clk);
      check("t6_mid_pulse_high", out[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_async_clear", out, 16'h0);
      check("t6_async_pws", pwm_period_start, 1'b0);
      repeat (2) @(negedge clk);
      check("t6_held_in_reset", out, 16'h0);
      rst_n = 1'b1;
      #1;
      check("t6_no_edge_yet", out, 16'h0);
      hi = 0;
      for (int k = 1; k <= PER; k++) begin
         @(negedge clk);
`ifdef PWM_DUTY_SHADOW_EN
         if (k == 1) check("t6_first_after_release", out[0], 1'b0);
`else
         if (k == 1) check("t6_first_after_release", out[0], 1'b1);
`endif
         if (out[0] === 1'b1) hi++;
      end
      check("t6_restart_period", pwm_period_start, 1'b1);
`ifdef PWM_DUTY_SHADOW_EN
      check("t6_high_after_release", hi, 0);
`else
      check("t6_high_after_release", hi, 64 * P);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
